// File: rtl/mic_spi_pkg.sv
// Shared constants, state encoding and command-bit helper for the
// MCP3002-style microphone ADC reader.
package mic_spi_pkg;

  localparam int unsigned FRAME_BITS   = 16;
  localparam int unsigned CMD_BITS     = 4;
  localparam logic [CMD_BITS-1:0] CMD_WORD = 4'b1101;  // start, single-ended, ch0, MSB-first
  localparam int unsigned DATA_MSB_POS = 5;             // SCK period carrying D9
  localparam int unsigned ADC_BITS     = 10;
  localparam int unsigned SAMPLE_BITS  = 8;
  localparam int unsigned BIT_CNT_W    = $clog2(2 * FRAME_BITS);

  // Shift-register index holding D9 once all FRAME_BITS have been shifted in MSB-first.
  localparam int unsigned DATA_HI      = FRAME_BITS - 1 - DATA_MSB_POS;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    DONE
  } state_t;

  // Command bit presented during SCK period 'period'; periods past the word give 0.
  function automatic logic cmd_bit(input logic [BIT_CNT_W-1:0] period);
    logic [CMD_BITS-1:0] word;
    word = CMD_WORD << period;
    return word[CMD_BITS-1];
  endfunction

endpackage

// File: rtl/microphone_sampler_tick.sv
// spi_tick_gen: half-period divider. Counts 0..CLK_DIV-1 and raises tick
// while the count sits at its terminal value.
// Ports: clk, rst_n (async active-low), clear (restart count at 0), tick.
module spi_tick_gen #(
  parameter int unsigned CLK_DIV = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // Next count; tick is registered from it so it is high exactly while cnt == LAST.
  always_comb begin
    cnt_nxt = cnt + CNT_W'(1);
    if (clear || (cnt == LAST)) begin
      cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      tick <= (cnt_nxt == LAST);
    end
  end

endmodule

// File: rtl/microphone_sampler.sv
// microphone_sampler: free-running SPI master reading a 10-bit SAR ADC and
// publishing the top 8 bits of each conversion.
// Ports: spi_clk/spi_mosi/spi_cs (SPI mode 0 master outputs), spi_miso (ADC data),
// clk, rst (async active-low), sample (latest D9..D2, held between frames).
module microphone_sampler
  import mic_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 25,
  parameter int unsigned CS_IDLE = 4
) (
  output logic                   spi_clk,
  output logic                   spi_mosi,
  output logic                   spi_cs,
  input  logic                   spi_miso,
  input  logic                   clk,
  input  logic                   rst,
  output logic [SAMPLE_BITS-1:0] sample
);

  localparam int unsigned IDLE_W = (CS_IDLE > 1) ? $clog2(CS_IDLE) : 1;
  localparam logic [IDLE_W-1:0]    IDLE_LAST  = IDLE_W'(CS_IDLE - 1);
  localparam logic [BIT_CNT_W-1:0] SHIFT_LAST = BIT_CNT_W'(2 * FRAME_BITS - 1);

  state_t                   state, state_nxt;
  logic                     tick;
  logic                     clear_c;
  logic [IDLE_W-1:0]        idle_cnt, idle_cnt_nxt;
  logic [BIT_CNT_W-1:0]     bit_cnt, bit_cnt_nxt;
  logic [FRAME_BITS-1:0]    shreg, shreg_nxt;
  logic                     spi_clk_nxt, spi_mosi_nxt, spi_cs_nxt;
  logic [SAMPLE_BITS-1:0]   sample_nxt;

  // DONE does not wait for a tick, so the divider restarts there to keep the
  // following idle gap a whole number of half-periods.
  spi_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst),
    .clear(clear_c),
    .tick (tick)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      idle_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      spi_clk  <= 1'b0;
      spi_mosi <= 1'b0;
      spi_cs   <= 1'b1;
      sample   <= '0;
    end else begin
      state    <= state_nxt;
      idle_cnt <= idle_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shreg    <= shreg_nxt;
      spi_clk  <= spi_clk_nxt;
      spi_mosi <= spi_mosi_nxt;
      spi_cs   <= spi_cs_nxt;
      sample   <= sample_nxt;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_nxt    = state;
    idle_cnt_nxt = idle_cnt;
    bit_cnt_nxt  = bit_cnt;
    shreg_nxt    = shreg;
    spi_clk_nxt  = spi_clk;
    spi_mosi_nxt = spi_mosi;
    spi_cs_nxt   = spi_cs;
    sample_nxt   = sample;
    clear_c      = 1'b0;

    case (state)
      IDLE: begin
        if (tick) begin
          if (idle_cnt == IDLE_LAST) begin
            state_nxt    = SETUP;
            idle_cnt_nxt = '0;
            spi_cs_nxt   = 1'b0;
            spi_mosi_nxt = cmd_bit('0);
          end else begin
            idle_cnt_nxt = idle_cnt + IDLE_W'(1);
          end
        end
      end

      SETUP: begin
        if (tick) begin
          state_nxt   = SHIFT;
          bit_cnt_nxt = '0;
        end
      end

      SHIFT: begin
        if (tick) begin
          bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
          if (!bit_cnt[0]) begin
            // Rising edge: capture MISO, MSB-first.
            spi_clk_nxt = 1'b1;
            shreg_nxt   = (shreg << 1) | FRAME_BITS'(spi_miso);
          end else begin
            // Falling edge: present the bit for the next SCK period.
            spi_clk_nxt  = 1'b0;
            spi_mosi_nxt = cmd_bit(BIT_CNT_W'(bit_cnt[BIT_CNT_W-1:1]) + BIT_CNT_W'(1));
          end
          if (bit_cnt == SHIFT_LAST) begin
            state_nxt  = DONE;
            spi_cs_nxt = 1'b1;
          end
        end
      end

      DONE: begin
        sample_nxt = shreg[DATA_HI -: SAMPLE_BITS];
        state_nxt  = IDLE;
        clear_c    = 1'b1;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_microphone_sampler.sv
// Directed self-checking bench for microphone_sampler with an MCP3002-style
// ADC model and an SPI bus monitor sampled on the falling edge of clk.
module tb_microphone_sampler;

  logic       spi_clk;
  logic       spi_mosi;
  logic       spi_cs;
  logic       spi_miso = 1'b0;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] sample;

  microphone_sampler #(
    .CLK_DIV(25),
    .CS_IDLE(4)
  ) dut (
    .spi_clk (spi_clk),
    .spi_mosi(spi_mosi),
    .spi_cs  (spi_cs),
    .spi_miso(spi_miso),
    .clk     (clk),
    .rst     (rst),
    .sample  (sample)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ADC model state
  logic [9:0] adc_word = 10'h000;
  logic       junk     = 1'b0;
  int         period   = 0;

  // Monitor state
  logic        prev_cs     = 1'b1;
  logic        prev_sck    = 1'b0;
  logic [7:0]  prev_sample = 8'h00;
  int          rises = 0, last_rises = 0, n_cs_rise = 0;
  int          cs_fall_cyc = -1, cs_fall_prev = -1, cs_rise_cyc = -1, gap = 0;
  int          rise_cyc = 0, rise_prev = 0, chg_cyc = 0, chg_prev = 0;
  logic [15:0] mosi_acc = 16'h0, mosi_word = 16'h0;
  logic        clk_at_cs_rise = 1'b1;
  int          rel = 0;

  function automatic logic miso_bit(input int p);
    if (p >= 5 && p <= 14) return adc_word[14-p];
    return junk;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Bus monitor and ADC data launch (ADC shifts out on SCK falling edges).
  always @(negedge clk) begin
    if (prev_cs && !spi_cs) begin
      if (cs_rise_cyc >= 0) gap = cyc - cs_rise_cyc;
      cs_fall_prev = cs_fall_cyc;
      cs_fall_cyc  = cyc;
      rises        = 0;
      mosi_acc     = 16'h0;
      period       = 0;
      spi_miso     = miso_bit(0);
    end
    if (!spi_cs && prev_sck && !spi_clk) begin
      period   = period + 1;
      spi_miso = miso_bit(period);
    end
    if (!prev_sck && spi_clk) begin
      rises     = rises + 1;
      mosi_acc  = {mosi_acc[14:0], spi_mosi};
      rise_prev = rise_cyc;
      rise_cyc  = cyc;
    end
    if (!prev_cs && spi_cs) begin
      n_cs_rise      = n_cs_rise + 1;
      cs_rise_cyc    = cyc;
      last_rises     = rises;
      clk_at_cs_rise = spi_clk;
      mosi_word      = mosi_acc;
    end
    if (sample !== prev_sample) begin
      chg_prev = chg_cyc;
      chg_cyc  = cyc;
    end
    prev_cs     = spi_cs;
    prev_sck    = spi_clk;
    prev_sample = sample;
  end

  task automatic wait_frame(input string tag);
    int start;
    int n;
    start = n_cs_rise;
    n     = 0;
    while (n_cs_rise == start && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n_cs_rise != start), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    rst      = 1'b0;
    adc_word = 10'h3FF;
    junk     = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_cs",     32'(spi_cs),   32'd1);
    chk("rst_sck",    32'(spi_clk),  32'd0);
    chk("rst_mosi",   32'(spi_mosi), 32'd0);
    chk("rst_sample", 32'(sample),   32'h00);

    // Frame 1: full-scale code
    rel = cyc;
    rst = 1'b1;
    wait_frame("frame1_done");
    chk("f1_sample",      32'(sample), 32'hFF);
    chk("f1_first_cs",    32'(cs_fall_cyc - rel), 32'd100);
    chk("f1_sck_rises",   32'(last_rises), 32'd16);
    chk("f1_mosi_word",   32'(mosi_word), 32'hD000);
    chk("f1_sck_at_cs_hi", 32'(clk_at_cs_rise), 32'd0);
    chk("f1_update_lat",  32'(chg_cyc - cs_rise_cyc), 32'd1);
    chk("f1_sck_period",  32'(rise_cyc - rise_prev), 32'd50);

    // Frame 2: 0x2A5 -> 0xA9
    adc_word = 10'h2A5;
    wait_frame("frame2_done");
    chk("f2_sample",       32'(sample), 32'hA9);
    chk("f2_frame_period", 32'(cs_fall_cyc - cs_fall_prev), 32'd926);
    chk("f2_cs_gap_ge100", 32'(gap >= 100), 32'd1);
    chk("f2_update_space", 32'(chg_cyc - chg_prev), 32'd926);

    // Frame 3: low bits truncated
    adc_word = 10'h003;
    wait_frame("frame3_done");
    chk("f3_sample",     32'(sample), 32'h00);
    chk("f3_sck_rises",  32'(last_rises), 32'd16);
    chk("f3_mosi_word",  32'(mosi_word), 32'hD000);

    // Frame 4: ones on command, null and trailing periods must be ignored
    adc_word = 10'h2A5;
    junk     = 1'b1;
    wait_frame("frame4_done");
    chk("f4_junk_sample", 32'(sample), 32'hA9);

    // Frame 5: reset mid-frame after 8 SCK periods
    adc_word = 10'h3FF;
    junk     = 1'b0;
    n = 0;
    while (spi_cs !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
    n = 0;
    while (rises < 8 && n < 2000) begin @(negedge clk); n++; end
    chk("mid_reached_8", 32'(rises >= 8), 32'd1);
    repeat (30) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_cs",     32'(spi_cs),   32'd1);
    chk("mid_rst_sck",    32'(spi_clk),  32'd0);
    chk("mid_rst_mosi",   32'(spi_mosi), 32'd0);
    chk("mid_rst_sample", 32'(sample),   32'h00);
    repeat (10) @(negedge clk);
    chk("mid_hold_sample", 32'(sample), 32'h00);
    chk("mid_hold_cs",     32'(spi_cs), 32'd1);
    rel = cyc;
    rst = 1'b1;
    wait_frame("frame6_done");
    chk("f6_sample",   32'(sample), 32'hFF);
    chk("f6_first_cs", 32'(cs_fall_cyc - rel), 32'd100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
